// File: rtl/sparse_match_sequencer.sv
// Sparse match sequencer: ANDs IFM/filter bitmap chunks and walks the set bits
// of the result lowest-index first, one match per output beat, across a tile
// of CHUNK_CNT chunks. It tracks the chunk index, flags the last match of each
// chunk, counts the matches in the tile and pulses tile_done_o when the tile ends.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high. Valid never depends on ready. While a beat is stalled
// (out_valid_o & !out_ready_i), every out_* field holds stable. in_ready_o is
// high only in LOAD and out_valid_o only in SCAN, so input acceptance and match
// beats never overlap in the same cycle.
module sparse_match_sequencer #(
  parameter  int SIZE      = 128,
  parameter  int CHUNK_CNT = 4,
  localparam int ADDR_W    = $clog2(SIZE),
  localparam int CIDX_W    = (CHUNK_CNT > 1) ? $clog2(CHUNK_CNT) : 1,
  localparam int CNT_W     = $clog2(SIZE * CHUNK_CNT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SIZE-1:0]   in1_i,
  input  logic [SIZE-1:0]   in2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] match_addr_o,
  output logic [CIDX_W-1:0] chunk_idx_o,
  output logic              chunk_last_o,
  output logic              tile_done_o,
  output logic [CNT_W-1:0]  match_cnt_o
);

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state;
  logic [SIZE-1:0]    mask_r;
  logic [CIDX_W-1:0]  chunk_cnt_r;
  logic [CIDX_W-1:0]  cidx_r;
  logic [CNT_W-1:0]   match_cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               tile_done_r;

  logic [SIZE-1:0]    in_mask;
  logic [SIZE-1:0]    mask_rest;
  logic [ADDR_W-1:0]  low_addr;
  logic               one_left;
  logic               last_chunk;
  logic [CIDX_W-1:0]  chunk_cnt_nxt;

  // Chunk match mask, the mask with its lowest set bit removed, and chunk counter wrap.
  always_comb begin
    in_mask       = in1_i & in2_i;
    mask_rest     = mask_r & (mask_r - SIZE'(1));
    one_left      = (mask_r != '0) && (mask_rest == '0);
    last_chunk    = (chunk_cnt_r == CIDX_W'(CHUNK_CNT - 1));
    chunk_cnt_nxt = last_chunk ? '0 : chunk_cnt_r + CIDX_W'(1);
  end

  // Priority encoder: position of the lowest set bit of the working mask.
  always_comb begin
    low_addr = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (mask_r[i]) low_addr = ADDR_W'(i);
    end
  end

  // Sequencer FSM with registered handshake flags, mask, counters and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= LOAD;
      mask_r      <= '0;
      chunk_cnt_r <= '0;
      cidx_r      <= '0;
      match_cnt_r <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      tile_done_r <= 1'b0;
    end else begin
      tile_done_r <= 1'b0;
      if (flush_i) begin
        // Abort wins over any handshake in the same cycle.
        state       <= LOAD;
        mask_r      <= '0;
        chunk_cnt_r <= '0;
        cidx_r      <= '0;
        match_cnt_r <= '0;
        in_ready_r  <= 1'b1;
        out_valid_r <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (in_valid_i) begin
              mask_r <= in_mask;
              cidx_r <= chunk_cnt_r;
              // Chunk 0 starts a new tile; the previous tile count is held until here.
              if (chunk_cnt_r == '0) match_cnt_r <= '0;
              if (in_mask != '0) begin
                state       <= SCAN;
                in_ready_r  <= 1'b0;
                out_valid_r <= 1'b1;
              end else begin
                // Empty chunk: nothing to emit, it completes on acceptance.
                chunk_cnt_r <= chunk_cnt_nxt;
                tile_done_r <= last_chunk;
              end
            end
          end
          SCAN: begin
            if (out_ready_i) begin
              mask_r      <= mask_rest;
              match_cnt_r <= match_cnt_r + CNT_W'(1);
              if (one_left) begin
                state       <= LOAD;
                in_ready_r  <= 1'b1;
                out_valid_r <= 1'b0;
                chunk_cnt_r <= chunk_cnt_nxt;
                tile_done_r <= last_chunk;
              end
            end
          end
          default: begin
            state       <= LOAD;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // The ready register resets high, so it is masked while reset is held.
  assign in_ready_o   = in_ready_r & ~rst_i;
  assign out_valid_o  = out_valid_r;
  assign match_addr_o = low_addr;
  assign chunk_idx_o  = cidx_r;
  assign chunk_last_o = one_left;
  assign tile_done_o  = tile_done_r;
  assign match_cnt_o  = match_cnt_r;

endmodule

// File: tb/tb_sparse_match_sequencer.sv
// Directed bench for sparse_match_sequencer: a tile vector table plus
// hand-written sequences for reset, backpressure, empty tile and flush.
module tb_sparse_match_sequencer;

  localparam int SIZE      = 128;
  localparam int CHUNK_CNT = 4;
  localparam int ADDR_W    = 7;
  localparam int CIDX_W    = 2;
  localparam int CNT_W     = 10;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [SIZE-1:0]   in1_i = '0;
  logic [SIZE-1:0]   in2_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [ADDR_W-1:0] match_addr_o;
  logic [CIDX_W-1:0] chunk_idx_o;
  logic              chunk_last_o;
  logic              tile_done_o;
  logic [CNT_W-1:0]  match_cnt_o;

  sparse_match_sequencer #(.SIZE(SIZE), .CHUNK_CNT(CHUNK_CNT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in1_i        (in1_i),
    .in2_i        (in2_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .match_addr_o (match_addr_o),
    .chunk_idx_o  (chunk_idx_o),
    .chunk_last_o (chunk_last_o),
    .tile_done_o  (tile_done_o),
    .match_cnt_o  (match_cnt_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [ADDR_W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int td_count = 0;

  // Count tile_done pulses, sampled mid-cycle
  always @(negedge clk_i) begin
    if (tile_done_o === 1'b1) td_count <= td_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Driver: offer one pair, then drain its beats. stall cycles of out_ready_i=0
  // are inserted before the first beat. Expected addresses come from the queue.
  task automatic send_pair(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                           input int exp_cidx, input int stall,
                           output int beats, output int cycles,
                           output logic [ADDR_W-1:0] first);
    logic [SIZE-1:0] m;
    int n, guard, left;
    m = a & b;
    n = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (m[i]) begin
        exp_q.push_back(ADDR_W'(i));
        n++;
      end
    end
    guard = 0;
    while (in_ready_o !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_pair", 32'(in_ready_o), 32'd1);
    in1_i = a; in2_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0; in1_i = '0; in2_i = '0;
    beats = 0; cycles = 0; first = '0;
    left = (n > 0) ? stall : 0;
    guard = 0;
    while (beats < n && guard < n + stall + 20) begin
      if (left > 0) begin
        out_ready_i = 1'b0;
        check("stall_valid", 32'(out_valid_o), 32'd1);
        check("stall_addr", 32'(match_addr_o), 32'(exp_q[0]));
        left--;
      end else begin
        out_ready_i = 1'b1;
        if (out_valid_o === 1'b1) begin
          if (beats == 0) first = match_addr_o;
          check("beat_addr", 32'(match_addr_o), 32'(exp_q.pop_front()));
          check("beat_cidx", 32'(chunk_idx_o), 32'(exp_cidx));
          check("beat_last", 32'(chunk_last_o), 32'(beats == n - 1));
          beats++;
        end
      end
      tick();
      cycles++;
      guard++;
    end
    out_ready_i = 1'b0;
    if (beats < n) begin
      check("beat_timeout", 32'(beats), 32'(n));
      exp_q.delete();
    end
    check("idle_after_chunk", 32'(out_valid_o), 32'd0);
  endtask

  typedef struct {
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    int                cidx;
    int                beats;
    logic [ADDR_W-1:0] first;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int beats, cycles, td0, total;
    logic [ADDR_W-1:0] first;

    tbl[0] = '{a: 128'hF0,            b: 128'hB0,  cidx: 0, beats: 3,   first: 7'd4};
    tbl[1] = '{a: 128'hFF00,          b: 128'h00FF, cidx: 1, beats: 0,  first: 7'd0};
    tbl[2] = '{a: {1'b1, 127'b0},     b: '1,        cidx: 2, beats: 1,  first: 7'd127};
    tbl[3] = '{a: '1,                 b: '1,        cidx: 3, beats: 128, first: 7'd0};

    // T1: reset values while held and after release
    #2 rst_i = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_tile_done", 32'(tile_done_o), 32'd0);
    check("rst_match_cnt", 32'(match_cnt_o), 32'd0);
    check("rst_chunk_idx", 32'(chunk_idx_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready_o), 32'd1);
    check("rel_match_cnt", 32'(match_cnt_o), 32'd0);
    check("rel_chunk_idx", 32'(chunk_idx_o), 32'd0);
    tick();

    // T2: 0x0F & 0x0A -> beats at 1 and 3, back to back
    send_pair(128'h0F, 128'h0A, 0, 0, beats, cycles, first);
    check("t2_beats", 32'(beats), 32'd2);
    check("t2_cycles", 32'(cycles), 32'd2);
    check("t2_first", 32'(first), 32'd1);
    check("t2_match_cnt", 32'(match_cnt_o), 32'd2);

    // T3: same pair as chunk 1 with three stall cycles before the first beat
    send_pair(128'h0F, 128'h0A, 1, 3, beats, cycles, first);
    check("t3_beats", 32'(beats), 32'd2);
    check("t3_cycles", 32'(cycles), 32'd5);
    check("t3_match_cnt", 32'(match_cnt_o), 32'd4);

    // T1 (cont.): reset asserted mid-SCAN
    in1_i = 128'hFF; in2_i = 128'hFF; in_valid_i = 1'b1; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    check("mid_scan_valid", 32'(out_valid_o), 32'd1);
    check("mid_scan_cidx", 32'(chunk_idx_o), 32'd2);
    rst_i = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready_o), 32'd0);
    check("mid_rst_match_cnt", 32'(match_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("mid_rel_in_ready", 32'(in_ready_o), 32'd1);
    check("mid_rel_chunk_idx", 32'(chunk_idx_o), 32'd0);
    tick();

    // T4: tile with 3,0,1,128 matches
    td0 = td_count;
    total = 0;
    for (int v = 0; v < 4; v++) begin
      send_pair(tbl[v].a, tbl[v].b, tbl[v].cidx, 0, beats, cycles, first);
      total += beats;
      check("t4_beats", 32'(beats), 32'(tbl[v].beats));
      check("t4_cycles", 32'(cycles), 32'(tbl[v].beats));
      if (tbl[v].beats > 0) check("t4_first", 32'(first), 32'(tbl[v].first));
      check("t4_chunk_idx", 32'(chunk_idx_o), 32'(tbl[v].cidx));
      check("t4_tile_done", 32'(tile_done_o), 32'(v == 3));
    end
    check("t4_total", 32'(total), 32'd132);
    check("t4_match_cnt", 32'(match_cnt_o), 32'd132);
    tick();
    check("t4_done_pulse_end", 32'(tile_done_o), 32'd0);
    check("t4_done_count", 32'(td_count - td0), 32'd1);
    check("t4_match_cnt_hold", 32'(match_cnt_o), 32'd132);

    // T5: empty tile, tile_done follows the 4th acceptance
    td0 = td_count;
    for (int c = 0; c < 4; c++) begin
      send_pair(128'h5555_0000_FFFF_0123, 128'hAAAA_FFFF_0000_FEDC, c, 0, beats, cycles, first);
      check("t5_beats", 32'(beats), 32'd0);
      check("t5_chunk_idx", 32'(chunk_idx_o), 32'(c));
      check("t5_tile_done", 32'(tile_done_o), 32'(c == 3));
      check("t5_match_cnt", 32'(match_cnt_o), 32'd0);
    end
    tick();
    check("t5_done_count", 32'(td_count - td0), 32'd1);

    // T6: flush coincident with the last beat of chunk 3
    td0 = td_count;
    for (int c = 0; c < 3; c++) begin
      send_pair('0, '0, c, 0, beats, cycles, first);
    end
    in1_i = 128'h3; in2_i = 128'h3; in_valid_i = 1'b1; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    check("t6_cidx", 32'(chunk_idx_o), 32'd3);
    check("t6_addr0", 32'(match_addr_o), 32'd0);
    out_ready_i = 1'b1;
    tick();
    check("t6_addr1", 32'(match_addr_o), 32'd1);
    check("t6_last", 32'(chunk_last_o), 32'd1);
    check("t6_cnt_pre", 32'(match_cnt_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    check("t6_valid_drop", 32'(out_valid_o), 32'd0);
    check("t6_match_cnt", 32'(match_cnt_o), 32'd0);
    check("t6_tile_done", 32'(tile_done_o), 32'd0);
    tick();
    check("t6_done_count", 32'(td_count - td0), 32'd0);
    send_pair(128'h10, 128'h10, 0, 0, beats, cycles, first);
    check("t6_next_beats", 32'(beats), 32'd1);
    check("t6_next_first", 32'(first), 32'd4);
    check("t6_next_cnt", 32'(match_cnt_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
